// File: rtl/zeroheti_obi_apb_bridge.sv
// OBI-to-APB4 bridge: buffers granted OBI requests in a small FIFO, decodes
// each into one of NumApbSel equally sized APB regions and replies in order
// with exactly one rvalid pulse. Unmapped addresses and stalled peripherals
// return an error instead of hanging the bus.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | FIFO empty, or waiting one cycle before answering an unmapped head
// SETUP  | APB setup phase for the FIFO head (psel high, penable low)
// ACCESS | APB access phase, waiting for pready or the wait-counter limit
// RESP   | obi_rvalid_o pulse for the FIFO head, head popped at the edge
module zeroheti_obi_apb_bridge #(
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned ReqDepth      = 2,
    parameter int unsigned NumApbSel     = 4,
    parameter logic [31:0] SelBase       = 32'h0003_0000,
    parameter logic [31:0] SelSize       = 32'h0000_1000,
    parameter int unsigned TimeoutCycles = 255
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           obi_req_i,
    output logic                           obi_gnt_o,
    input  logic [AddrWidth-1:0]           obi_addr_i,
    input  logic                           obi_we_i,
    input  logic [DataWidth/8-1:0]         obi_be_i,
    input  logic [DataWidth-1:0]           obi_wdata_i,
    output logic                           obi_rvalid_o,
    output logic [DataWidth-1:0]           obi_rdata_o,
    output logic                           obi_err_o,
    output logic [NumApbSel-1:0]           psel_o,
    output logic                           penable_o,
    output logic [AddrWidth-1:0]           paddr_o,
    output logic                           pwrite_o,
    output logic [DataWidth/8-1:0]         pstrb_o,
    output logic [DataWidth-1:0]           pwdata_o,
    input  logic [NumApbSel*DataWidth-1:0] prdata_i,
    input  logic [NumApbSel-1:0]           pready_i,
    input  logic [NumApbSel-1:0]           pslverr_i
);
    localparam int unsigned BeWidth   = DataWidth / 8;
    localparam int unsigned IdxWidth  = (NumApbSel > 1) ? $clog2(NumApbSel) : 1;
    localparam int unsigned PtrWidth  = (ReqDepth > 1) ? $clog2(ReqDepth) : 1;
    localparam int unsigned CntWidth  = $clog2(ReqDepth + 1);
    localparam int unsigned WaitWidth = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
    localparam int unsigned SizeShift = $clog2(SelSize);

    localparam logic [WaitWidth-1:0] WaitLimit = WaitWidth'(TimeoutCycles);
    localparam logic [PtrWidth-1:0]  PtrLast   = PtrWidth'(ReqDepth - 1);
    localparam logic [CntWidth-1:0]  CntFull   = CntWidth'(ReqDepth);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t                state, state_nxt;
    logic [WaitWidth-1:0]  wait_cnt, wait_cnt_nxt;
    logic [DataWidth-1:0]  resp_rdata, resp_rdata_nxt;
    logic                  resp_err, resp_err_nxt;

    logic [AddrWidth-1:0]  fifo_addr  [ReqDepth];
    logic                  fifo_we    [ReqDepth];
    logic [BeWidth-1:0]    fifo_be    [ReqDepth];
    logic [DataWidth-1:0]  fifo_wdata [ReqDepth];
    logic [IdxWidth-1:0]   fifo_idx   [ReqDepth];
    logic                  fifo_mapped[ReqDepth];
    logic [PtrWidth-1:0]   wr_ptr, rd_ptr, rd_ptr_nxt;
    logic [CntWidth-1:0]   count;
    logic                  push, pop;

    logic [AddrWidth-1:0]  in_offset, in_region;
    logic                  in_mapped;
    logic [IdxWidth-1:0]   in_idx;

    logic [IdxWidth-1:0]   head_idx;
    logic                  head_we, head_mapped, next_mapped;
    logic                  sel_ready, sel_err;
    logic [DataWidth-1:0]  sel_rdata;
    logic                  active;

    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
        return (p == PtrLast) ? '0 : p + 1'b1;
    endfunction

    // Region decode of the incoming request; the result is stored with the entry.
    assign in_offset = obi_addr_i - AddrWidth'(SelBase);
    assign in_region = in_offset >> SizeShift;
    assign in_mapped = (obi_addr_i >= AddrWidth'(SelBase)) && (in_region < AddrWidth'(NumApbSel));
    assign in_idx    = in_region[IdxWidth-1:0];

    // Fullness is taken before this cycle's pop, so a full FIFO never pushes.
    assign obi_gnt_o  = rst_ni & obi_req_i & (count != CntFull);
    assign push       = obi_gnt_o;
    assign pop        = (state == RESP);
    assign rd_ptr_nxt = ptr_inc(rd_ptr);

    assign head_idx    = fifo_idx[rd_ptr];
    assign head_we     = fifo_we[rd_ptr];
    assign head_mapped = fifo_mapped[rd_ptr];
    assign next_mapped = fifo_mapped[rd_ptr_nxt];
    assign sel_ready   = pready_i[head_idx];
    assign sel_err     = pslverr_i[head_idx];
    assign sel_rdata   = prdata_i[head_idx*DataWidth +: DataWidth];

    // FIFO pointers and occupancy; reset drops every pending entry.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= rd_ptr_nxt;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
        end
    end

    // FIFO payload storage; contents are only observed through valid entries.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_addr[wr_ptr]   <= obi_addr_i;
            fifo_we[wr_ptr]     <= obi_we_i;
            fifo_be[wr_ptr]     <= obi_be_i;
            fifo_wdata[wr_ptr]  <= obi_wdata_i;
            fifo_idx[wr_ptr]    <= in_idx;
            fifo_mapped[wr_ptr] <= in_mapped;
        end
    end

    // State, wait counter and captured response.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            state      <= state_nxt;
            wait_cnt   <= wait_cnt_nxt;
            resp_rdata <= resp_rdata_nxt;
            resp_err   <= resp_err_nxt;
        end
    end

    // Next-state logic. A mapped request arriving at an empty bridge goes
    // straight to SETUP; an unmapped one is answered from IDLE a cycle later.
    always_comb begin
        state_nxt      = state;
        wait_cnt_nxt   = wait_cnt;
        resp_rdata_nxt = resp_rdata;
        resp_err_nxt   = resp_err;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    if (head_mapped) begin
                        state_nxt = SETUP;
                    end else begin
                        state_nxt      = RESP;
                        resp_err_nxt   = 1'b1;
                        resp_rdata_nxt = '0;
                    end
                end else if (push && in_mapped) begin
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                state_nxt    = ACCESS;
                wait_cnt_nxt = '0;
            end
            ACCESS: begin
                if (sel_ready) begin
                    state_nxt      = RESP;
                    resp_err_nxt   = sel_err;
                    resp_rdata_nxt = (head_we || sel_err) ? '0 : sel_rdata;
                end else if ((TimeoutCycles != 0) && (wait_cnt == WaitLimit)) begin
                    state_nxt      = RESP;
                    resp_err_nxt   = 1'b1;
                    resp_rdata_nxt = '0;
                end else begin
                    wait_cnt_nxt = wait_cnt + 1'b1;
                end
            end
            RESP: begin
                if (count > CntWidth'(1)) begin
                    if (next_mapped) begin
                        state_nxt = SETUP;
                    end else begin
                        state_nxt      = RESP;
                        resp_err_nxt   = 1'b1;
                        resp_rdata_nxt = '0;
                    end
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // APB and OBI outputs; all forced low while reset is asserted.
    assign active       = rst_ni && ((state == SETUP) || (state == ACCESS));
    assign psel_o       = active ? (NumApbSel'(1) << head_idx) : '0;
    assign penable_o    = rst_ni && (state == ACCESS);
    assign paddr_o      = active ? fifo_addr[rd_ptr] : '0;
    assign pwrite_o     = active && head_we;
    assign pstrb_o      = (active && head_we) ? fifo_be[rd_ptr] : '0;
    assign pwdata_o     = active ? fifo_wdata[rd_ptr] : '0;
    assign obi_rvalid_o = rst_ni && (state == RESP);
    assign obi_rdata_o  = obi_rvalid_o ? resp_rdata : '0;
    assign obi_err_o    = obi_rvalid_o && resp_err;

endmodule

// File: tb/tb_zeroheti_obi_apb_bridge.sv
// Self-checking bench for zeroheti_obi_apb_bridge: table of single
// transactions, hand-written FIFO-full and reset sequences, and a random
// run compared against a queue-based reference model.
module tb_zeroheti_obi_apb_bridge;
    localparam int DW = 32;
    localparam int NS = 4;
    localparam int TO = 8;

    logic              clk = 1'b0;
    logic              rst_ni;
    logic              obi_req_i, obi_gnt_o, obi_we_i, obi_rvalid_o, obi_err_o;
    logic [31:0]       obi_addr_i, obi_wdata_i, obi_rdata_o, paddr_o, pwdata_o;
    logic [3:0]        obi_be_i, pstrb_o, psel_o, pready_i, pslverr_i;
    logic              penable_o, pwrite_o;
    logic [NS*DW-1:0]  prdata_i;

    always #5 clk = ~clk;

    zeroheti_obi_apb_bridge #(.TimeoutCycles(TO)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .obi_req_i(obi_req_i), .obi_gnt_o(obi_gnt_o), .obi_addr_i(obi_addr_i),
        .obi_we_i(obi_we_i), .obi_be_i(obi_be_i), .obi_wdata_i(obi_wdata_i),
        .obi_rvalid_o(obi_rvalid_o), .obi_rdata_o(obi_rdata_o), .obi_err_o(obi_err_o),
        .psel_o(psel_o), .penable_o(penable_o), .paddr_o(paddr_o), .pwrite_o(pwrite_o),
        .pstrb_o(pstrb_o), .pwdata_o(pwdata_o), .prdata_i(prdata_i),
        .pready_i(pready_i), .pslverr_i(pslverr_i)
    );

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] addr; logic we; logic [3:0] be; logic [31:0] wdata;
        logic [31:0] srdata; logic serr; int waits;
        logic [31:0] exp_rdata; logic exp_err; logic [3:0] exp_psel; int exp_lat; int exp_acc;
    } vec_t;

    typedef struct { logic [31:0] addr; logic [31:0] rdata; logic err; } exp_t;

    vec_t vecs[10];
    exp_t q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic any_out();
        return obi_gnt_o | obi_rvalid_o | obi_err_o | penable_o | pwrite_o | (|psel_o) |
               (|pstrb_o) | (|obi_rdata_o) | (|paddr_o) | (|pwdata_o);
    endfunction

    // selected region gets the given response, every other region random noise
    task automatic set_slave(input logic [31:0] rd, input logic er, input logic rdy);
        for (int r = 0; r < NS; r++) begin
            if (psel_o[r]) begin
                prdata_i[r*DW +: DW] = rd; pslverr_i[r] = er; pready_i[r] = rdy;
            end else begin
                prdata_i[r*DW +: DW] = $urandom; pslverr_i[r] = 1'($urandom); pready_i[r] = 1'($urandom);
            end
        end
    endtask

    // reference model rules
    function automatic bit m_mapped(input logic [31:0] a);
        return (a >= 32'h0003_0000) && (a < 32'h0003_4000);
    endfunction
    function automatic logic [3:0] m_psel(input logic [31:0] a);
        return 4'b0001 << ((a - 32'h0003_0000) / 32'h1000);
    endfunction
    function automatic logic [31:0] m_data(input logic [31:0] a);
        return ~a ^ 32'h1357_9BDF;
    endfunction
    function automatic bit m_serr(input logic [31:0] a);
        return a[5:4] == 2'b11;
    endfunction

    task automatic run_vec(input vec_t v);
        int acc = 0;
        bit done = 0;
        bit seen = 0;
        @(posedge clk); #1;
        obi_req_i = 1'b1; obi_addr_i = v.addr; obi_we_i = v.we; obi_be_i = v.be; obi_wdata_i = v.wdata;
        set_slave(v.srdata, v.serr, 1'b0);
        #1;
        chk("vec_gnt", obi_gnt_o, 1);
        for (int c = 1; c <= 40 && !done; c++) begin
            @(posedge clk); #1;
            obi_req_i = 1'b0; obi_addr_i = $urandom; obi_wdata_i = $urandom;
            if (penable_o) acc++;
            set_slave(v.srdata, v.serr, acc > v.waits);
            #1;
            if (psel_o != 0) begin
                seen = 1;
                chk("vec_psel", psel_o, v.exp_psel);
                chk("vec_paddr", paddr_o, v.addr);
                chk("vec_pwrite", pwrite_o, v.we);
                chk("vec_pstrb", pstrb_o, v.we ? v.be : 4'h0);
                if (v.we) chk("vec_pwdata", pwdata_o, v.wdata);
            end
            if (obi_rvalid_o) begin
                done = 1;
                chk("vec_latency", c, v.exp_lat);
                chk("vec_rdata", obi_rdata_o, v.exp_rdata);
                chk("vec_err", obi_err_o, v.exp_err);
            end else begin
                chk("vec_gate", {obi_rdata_o, obi_err_o}, 0);
            end
        end
        chk("vec_done", done, 1);
        chk("vec_psel_seen", seen, v.exp_psel != 0);
        chk("vec_access_cycles", acc, v.exp_acc);
    endtask

    initial begin
        logic [31:0] fexp_rdata [4];
        logic        fexp_err   [4];
        logic [7:0]  fexp_gnt;
        int ni, nr, outstanding;
        bit have;
        logic [31:0] addr;

        //          addr          we    be     wdata         srdata        serr  waits  rdata         err   psel     lat acc
        vecs[0] = '{32'h0003_1004, 1'b0, 4'hF, 32'h0,        32'hCAFE_F00D, 1'b0, 0,    32'hCAFE_F00D, 1'b0, 4'b0010, 3,  1};
        vecs[1] = '{32'h0003_0008, 1'b1, 4'h6, 32'h1234_5678, 32'hFFFF_FFFF, 1'b0, 3,    32'h0,         1'b0, 4'b0001, 6,  4};
        vecs[2] = '{32'h0003_4000, 1'b0, 4'hF, 32'h0,        32'h1111_1111, 1'b0, 0,    32'h0,         1'b1, 4'b0000, 2,  0};
        vecs[3] = '{32'h0002_FFFC, 1'b0, 4'hF, 32'h0,        32'h2222_2222, 1'b0, 0,    32'h0,         1'b1, 4'b0000, 2,  0};
        vecs[4] = '{32'h0003_3FFC, 1'b0, 4'hF, 32'h0,        32'h1122_3344, 1'b0, 1,    32'h1122_3344, 1'b0, 4'b1000, 4,  2};
        vecs[5] = '{32'h0003_2010, 1'b0, 4'hF, 32'h0,        32'hDEAD_BEEF, 1'b1, 0,    32'h0,         1'b1, 4'b0100, 3,  1};
        vecs[6] = '{32'h0003_3000, 1'b1, 4'hF, 32'h0000_A5A5, 32'h3333_3333, 1'b1, 2,    32'h0,         1'b1, 4'b1000, 5,  3};
        vecs[7] = '{32'h0003_2000, 1'b0, 4'hF, 32'h0,        32'h1234_5678, 1'b0, 1000, 32'h0,         1'b1, 4'b0100, 11, TO+1};
        vecs[8] = '{32'hFFFF_FFFC, 1'b0, 4'hF, 32'h0,        32'h4444_4444, 1'b0, 0,    32'h0,         1'b1, 4'b0000, 2,  0};
        vecs[9] = '{32'h0003_0FFC, 1'b0, 4'hF, 32'h0,        32'h0BAD_CAFE, 1'b0, 0,    32'h0BAD_CAFE, 1'b0, 4'b0001, 3,  1};

        rst_ni = 1'b0; obi_req_i = 1'b0; obi_addr_i = '0; obi_we_i = 1'b0; obi_be_i = '0;
        obi_wdata_i = '0; prdata_i = '0; pready_i = '0; pslverr_i = '0;
        repeat (3) @(posedge clk);
        #1; obi_req_i = 1'b1; obi_addr_i = 32'h0003_1000;
        #1; chk("reset_outputs", any_out(), 0);
        @(posedge clk); #1;
        rst_ni = 1'b1; obi_req_i = 1'b0;
        #1; chk("post_reset_outputs", any_out(), 0);

        foreach (vecs[i]) run_vec(vecs[i]);

        // FIFO full: req held high, all regions ready, region 2 reports slverr
        fexp_gnt = 8'b1001_0011;
        for (int r = 0; r < 4; r++) begin
            fexp_rdata[r] = (r == 2) ? 32'h0 : (32'hA000_0000 | r);
            fexp_err[r]   = (r == 2);
        end
        ni = 0; nr = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            obi_req_i = (ni < 4); obi_we_i = 1'b0; obi_be_i = 4'hF;
            obi_addr_i = 32'h0003_0000 + ni * 32'h1000 + ni * 4;
            for (int r = 0; r < NS; r++) begin
                prdata_i[r*DW +: DW] = 32'hA000_0000 | r; pready_i[r] = 1'b1; pslverr_i[r] = (r == 2);
            end
            #1;
            if (c < 8) chk("full_gnt", obi_gnt_o, fexp_gnt[c]);
            if (obi_gnt_o) ni++;
            if (obi_rvalid_o) begin
                if (nr < 4) begin
                    chk("full_rvalid_cycle", c, 3 + 3 * nr);
                    chk("full_rdata", obi_rdata_o, fexp_rdata[nr]);
                    chk("full_err", obi_err_o, fexp_err[nr]);
                end
                nr++;
            end
        end
        chk("full_responses", nr, 4);

        // reset while one entry is in ACCESS and a second is queued
        @(posedge clk); #1;
        obi_req_i = 1'b1; obi_addr_i = 32'h0003_1000; obi_we_i = 1'b0; pready_i = '0;
        @(posedge clk); #1;
        obi_addr_i = 32'h0003_2000; pready_i = '0;
        #1; chk("rst_seq_gnt2", obi_gnt_o, 1);
        @(posedge clk); #1;
        obi_req_i = 1'b0; pready_i = '0;
        #1; chk("rst_seq_access", penable_o, 1);
        @(posedge clk); #1;
        rst_ni = 1'b0; obi_req_i = 1'b1; obi_addr_i = 32'h0003_3000;
        #1; chk("rst_seq_in_reset", any_out(), 0);
        @(posedge clk); #1;
        rst_ni = 1'b1; obi_req_i = 1'b0;
        #1; chk("rst_seq_after_edge", any_out(), 0);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            pready_i = '1;
            #1; chk("rst_seq_no_stale", {obi_rvalid_o, psel_o}, 0);
        end
        run_vec(vecs[0]);

        // random traffic against the queue model
        have = 0; outstanding = 0; addr = '0;
        for (int c = 0; c < 520; c++) begin
            int acc;
            @(posedge clk); #1;
            if (!have && c < 420 && $urandom_range(0, 2) != 0) begin
                case ($urandom_range(0, 9))
                    7:       addr = 32'h0003_4000 + ($urandom_range(0, 32'hFFFF) & ~32'h3);
                    8:       addr = 32'h0002_0000 + ($urandom_range(0, 32'hFFFF) & ~32'h3);
                    9:       addr = $urandom & ~32'h3;
                    default: addr = 32'h0003_0000 + ($urandom_range(0, 32'h3FFF) & ~32'h3);
                endcase
                have = 1;
                obi_we_i = 1'($urandom); obi_be_i = 4'($urandom); obi_wdata_i = $urandom;
            end
            obi_req_i = have; obi_addr_i = addr;
            if (penable_o) acc++; else acc = 0;
            for (int r = 0; r < NS; r++) begin
                if (psel_o[r]) begin
                    prdata_i[r*DW +: DW] = m_data(paddr_o); pslverr_i[r] = m_serr(paddr_o);
                    pready_i[r] = (acc > int'(paddr_o[3:2]));
                end else begin
                    prdata_i[r*DW +: DW] = $urandom; pslverr_i[r] = 1'($urandom); pready_i[r] = 1'($urandom);
                end
            end
            #1;
            chk("rnd_gnt", obi_gnt_o, have && (outstanding < 2));
            if (psel_o != 0 && q.size() > 0) begin
                chk("rnd_paddr", paddr_o, q[0].addr);
                chk("rnd_psel", psel_o, m_psel(q[0].addr));
            end
            if (obi_rvalid_o) begin
                if (q.size() == 0) begin
                    chk("rnd_unexpected_rvalid", 1, 0);
                end else begin
                    chk("rnd_rdata", obi_rdata_o, q[0].rdata);
                    chk("rnd_err", obi_err_o, q[0].err);
                    void'(q.pop_front());
                    outstanding--;
                end
            end else begin
                chk("rnd_gate", {obi_rdata_o, obi_err_o}, 0);
            end
            if (obi_gnt_o) begin
                exp_t e;
                e.addr  = addr;
                e.err   = !m_mapped(addr) || m_serr(addr);
                e.rdata = (e.err || obi_we_i) ? 32'h0 : m_data(addr);
                q.push_back(e);
                outstanding++;
                have = 0;
            end
        end
        chk("rnd_drained", q.size(), 0);
        chk("rnd_pending_req", have, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end
endmodule

// File: doc/zeroheti_obi_apb_bridge.md
# zeroheti_obi_apb_bridge

Parametrised OBI-to-APB4 bridge that succeeds the single-target bridge behind the core crossbar's peripheral port. It buffers up to `ReqDepth` granted OBI requests and decodes each into one of `NumApbSel` equally sized APB regions with individual `psel_o` lines. Every access completes in order with exactly one `obi_rvalid_o` pulse. Unmapped addresses and stalled peripherals return an OBI error; they never hang the bus.

## Interface
- Clocking and reset: one clock; reset is synchronous and active-low.
- `AddrWidth`, 32: OBI/APB address width.
- `DataWidth`, 32: data width; `DataWidth/8` byte strobes.
- `ReqDepth`, 2: request FIFO entries, ≥1.
- `NumApbSel`, 4: number of APB select lines, ≥1.
- `SelBase`, 32'h0003_0000: base address of region 0.
- `SelSize`, 32'h0000_1000: bytes per region; power of two.
- `TimeoutCycles`, 255: maximum ACCESS cycles before forced error; 0 disables the timeout.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  synchronous active-low reset.
- `obi_req_i`  in  1  request valid.
- `obi_gnt_o`  out  1  request accepted.
- `obi_addr_i`  in  AddrWidth  byte address.
- `obi_we_i`  in  1  1 = write.
- `obi_be_i`  in  DataWidth/8  byte enables.
- `obi_wdata_i`  in  DataWidth  write data.
- `obi_rvalid_o`  out  1  response pulse.
- `obi_rdata_o`  out  DataWidth  read data; 0 for writes and errors.
- `obi_err_o`  out  1  error, valid with `obi_rvalid_o`.
- `psel_o`  out  NumApbSel  one-hot select.
- `penable_o`  out  1  APB access phase.
- `paddr_o`  out  AddrWidth  address with region offset; the full address is forwarded.
- `pwrite_o`  out  1  write.
- `pstrb_o`  out  DataWidth/8  strobes; 0 on reads.
- `pwdata_o`  out  DataWidth  write data.
- `prdata_i`  in  NumApbSel×DataWidth  per-region read data.
- `pready_i`  in  NumApbSel  per-region ready.
- `pslverr_i`  in  NumApbSel  per-region error.

## Operation
- **Grant:** `obi_gnt_o = obi_req_i & !full`. Fullness is evaluated before this cycle's pop, so a pop and a push in the same cycle when full are not allowed. A granted request is pushed at the clock edge.
- **Decode:** done at push time.
  - `idx = (addr - SelBase) >> log2(SelSize)`.
  - The address is mapped iff `addr ≥ SelBase` and `idx < NumApbSel`.
  - Each FIFO entry stores addr, we, be, wdata, idx and mapped.
- **FSM:** IDLE, SETUP, ACCESS, RESP.
  - IDLE: if the FIFO is non-empty, a mapped head goes to SETUP and an unmapped head goes to RESP with err=1.
  - SETUP: `psel_o[idx]=1`, `penable_o=0`. Next state is ACCESS.
  - ACCESS: `psel_o[idx]=1`, `penable_o=1`.
    - On `pready_i[idx]`, capture `prdata_i[idx]` (reads only) and `pslverr_i[idx]`, then go to RESP.
    - If the wait counter equals `TimeoutCycles` (non-zero), go to RESP with err=1 and rdata=0.
  - RESP: `obi_rvalid_o=1` for one cycle and the FIFO head is popped. Then SETUP if the next entry exists and is mapped, RESP again if it is unmapped, IDLE if the FIFO is empty.
- **Wait counter:** cleared on SETUP and incremented each ACCESS cycle without `pready_i[idx]`. Its width is `$clog2(TimeoutCycles+1)`, minimum 1.
- **APB outputs:** `paddr_o`, `pwrite_o`, `pstrb_o`, `pwdata_o` are driven from the FIFO head. They are held stable across SETUP and ACCESS and are 0 outside those states.
- **Data gating:** `obi_rdata_o` and `obi_err_o` are 0 whenever `obi_rvalid_o=0`.

## Timing
- **Reset:** every output is 0, the FIFO is empty, the FSM is in IDLE and the counter is 0.
  - A reset mid-transfer drops all pending entries.
  - No `obi_rvalid_o` is issued for dropped requests.
  - `psel_o` falls in the first reset cycle.
- **Zero-wait mapped access:** grant in cycle 0, SETUP in cycle 1, ACCESS with `pready` in cycle 2, `obi_rvalid_o` in cycle 3.
- **Throughput:** back-to-back mapped accesses take 3 cycles each (SETUP, ACCESS, RESP). The next SETUP immediately follows RESP.
- **Unmapped access:** grant in cycle 0, `obi_rvalid_o` with err=1 in cycle 2 (through IDLE).
- **Wait states:** each wait cycle adds 1 cycle of latency.
- **Timeout:** with `TimeoutCycles=N`, RESP follows after N+1 ACCESS cycles without `pready`.
- **Ordering:** responses are strictly in grant order, one per grant.
- **Grant while busy:** the FIFO accepts new requests in any FSM state while not full.
- **Ignored inputs:** `pready_i` and `pslverr_i` of non-selected regions are ignored.

## Test plan
- **Read, zero wait:** read 0x0003_1004 with region 1 `pready=1` and `prdata=0xCAFE_F00D`. Required: `psel_o=4'b0010` in cycles 1–2, `pstrb_o=0`, then rvalid in cycle 3 with rdata 0xCAFE_F00D and err=0.
- **Write, 3 wait states:** write 0x0003_0008 with be=4'b0110 and wdata 0x1234_5678 to region 0. Required: `pstrb_o=4'b0110` stable for 4 ACCESS cycles, then rvalid with rdata=0 and err=0.
- **Unmapped:** read 0x0003_4000 (idx 4). Required: no `psel_o` asserted, rvalid with err=1 two cycles after grant. Read 0x0002_FFFC also returns an error.
- **Timeout:** `TimeoutCycles=8` with region 2 `pready=0` forever. Required: ACCESS lasts 9 cycles, then rvalid with err=1 and rdata=0, and `psel_o` returns to 0.
- **FIFO full, ReqDepth=2:**
  - Stimulus: `obi_req_i` held high and all regions ready.
  - Required: grants in cycles 0 and 1, grant low in cycle 2 until the first pop.
  - Required: 4 requests are answered in order at a spacing of 3 cycles, including the `pslverr=1` error on the third.
- **Reset mid-ACCESS:**
  - Stimulus: assert `rst_ni=0` for 1 cycle while 2 entries are queued.
  - Required: all outputs are 0 after that edge and no stale rvalid follows.
  - Required: a new read completes normally afterwards.
